// File: rtl/cpr_pkg.sv
// Shared lane/tag geometry and helpers for the compressed-line datapath.
// Used by both the decompressor and the companion compressor blocks.
package cpr_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int LINE_W = LANES * LANE_W;
  localparam int TAG_W  = LANES;
  localparam int LEN_W  = 5;
  localparam int IDX_W  = 4;

  typedef logic [LANE_W-1:0] lane_t;

  function automatic logic [LEN_W-1:0] popcount16(input logic [TAG_W-1:0] v);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAG_W; i++) begin
      n = n + LEN_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/decompressor_if.sv
// Valid/ready bundle for the decompressor: packed word + tag in, line + tag/len/err out.
// The master drives the input side and the output-side ready; the slave is the block.
interface decompressor_if
  import cpr_pkg::*;
  ;

  logic              inValid;
  logic              inReady;
  logic [LINE_W-1:0] cprDataIn;
  logic [TAG_W-1:0]  tagIn;
  logic              outValid;
  logic              outReady;
  logic [LINE_W-1:0] dataOut;
  logic [TAG_W-1:0]  tagOut;
  logic [LEN_W-1:0]  lenOut;
  logic              errOut;

  modport master (
    output inValid, cprDataIn, tagIn, outReady,
    input  inReady, outValid, dataOut, tagOut, lenOut, errOut
  );

  modport slave (
    input  inValid, cprDataIn, tagIn, outReady,
    output inReady, outValid, dataOut, tagOut, lenOut, errOut
  );

endinterface

// File: rtl/lane_index_gen.sv
// Combinational prefix popcount over a lane tag: idx[i] counts set tag bits below lane i,
// len counts all set bits. Shared by the compressor packer and the decompressor expander.
module lane_index_gen
  import cpr_pkg::*;
(
  input  logic [TAG_W-1:0]            tag,
  output logic [LANES-1:0][IDX_W-1:0] idx,
  output logic [LEN_W-1:0]            len
);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      // idx never exceeds 15, so dropping the popcount MSB is lossless
      idx[i] = IDX_W'(popcount16(tag & ((TAG_W'(1) << i) - TAG_W'(1))));
    end
    len = popcount16(tag);
  end

endmodule

// File: rtl/decompressor.sv
// Two-stage decompressor: S1 registers the packed word and derives lane indices,
// S2 holds the expanded line. Skid-free valid/ready so both stages fill under backpressure.
module decompressor
  import cpr_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  decompressor_if.slave bus
);

  logic                       s1_adv;
  logic                       s2_adv;
  logic                       in_xfer;
  logic                       s2_load;

  logic                       vld_p1_q, vld_p1_d;
  logic [TAG_W-1:0]           tag_p1_q, tag_p1_d;
  lane_t [LANES-1:0]          data_p1_q, data_p1_d;

  logic [LANES-1:0][IDX_W-1:0] idx_p1;
  logic [LEN_W-1:0]           len_p1;
  lane_t [LANES-1:0]          line_p1;
  logic                       excess_p1;

  logic                       vld_p2_q, vld_p2_d;
  lane_t [LANES-1:0]          data_p2_q, data_p2_d;
  logic [TAG_W-1:0]           tag_p2_q, tag_p2_d;
  logic [LEN_W-1:0]           len_p2_q, len_p2_d;
  logic                       err_q, err_d;

  lane_index_gen u_lane_index_gen (
    .tag (tag_p1_q),
    .idx (idx_p1),
    .len (len_p1)
  );

  // Input -> S1
  always_comb begin
    s2_adv  = !vld_p2_q || bus.outReady;
    s1_adv  = !vld_p1_q || s2_adv;
    in_xfer = bus.inValid && s1_adv;
    s2_load = vld_p1_q && s2_adv;

    vld_p1_d  = s1_adv ? bus.inValid : vld_p1_q;
    tag_p1_d  = tag_p1_q;
    data_p1_d = data_p1_q;
    if (in_xfer) begin
      tag_p1_d  = bus.tagIn;
      data_p1_d = bus.cprDataIn;
    end
  end

  // S1 -> S2: lane expansion and excess-lane check
  always_comb begin
    excess_p1 = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      line_p1[i] = tag_p1_q[i] ? data_p1_q[idx_p1[i]] : '0;
      if ((LEN_W'(i) >= len_p1) && (data_p1_q[i] != '0)) begin
        excess_p1 = 1'b1;
      end
    end

    vld_p2_d  = s2_adv ? vld_p1_q : vld_p2_q;
    data_p2_d = data_p2_q;
    tag_p2_d  = tag_p2_q;
    len_p2_d  = len_p2_q;
    if (s2_load) begin
      data_p2_d = line_p1;
      tag_p2_d  = tag_p1_q;
      len_p2_d  = len_p1;
    end
    err_d = err_q || (s2_load && excess_p1);
  end

  // Output registers are reset too, so the consumer sees a zero line after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      tag_p2_q  <= '0;
      len_p2_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      tag_p2_q  <= tag_p2_d;
      len_p2_q  <= len_p2_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_p1_q  <= tag_p1_d;
    data_p1_q <= data_p1_d;
  end

  assign bus.inReady  = s1_adv;
  assign bus.outValid = vld_p2_q;
  assign bus.dataOut  = data_p2_q;
  assign bus.tagOut   = tag_p2_q;
  assign bus.lenOut   = len_p2_q;
  assign bus.errOut   = err_q;

endmodule
